// File: rtl/parking_keypad_encoder_if.sv
// Keypad/controller-facing signal bundle for the parking PIN encoder.
// The master drives keypad strobes and verdicts; the slave presents the assembled code.
interface parking_keypad_encoder_if;
    logic        vehicle_arrival;
    logic        key_valid;
    logic [3:0]  key_value;
    logic        open_gate;
    logic        wrong_ping;
    logic        blocked_gate;
    logic [15:0] code;
    logic        code_ack;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        timeout;
    logic        busy;

    modport master (
        output vehicle_arrival, key_valid, key_value, open_gate, wrong_ping, blocked_gate,
        input  code, code_ack, digit_count, entry_error, timeout, busy
    );

    modport slave (
        input  vehicle_arrival, key_valid, key_value, open_gate, wrong_ping, blocked_gate,
        output code, code_ack, digit_count, entry_error, timeout, busy
    );
endinterface

// File: rtl/parking_keypad_encoder.sv
// Collects four BCD key presses into a PIN code word, hands it to the gate
// controller with a one-cycle ack and waits for the controller's verdict.
module parking_keypad_encoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TMR_W          = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    parking_keypad_encoder_if.slave bus
);

    localparam int unsigned CODE_W = 16;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned CNT_W  = 3;

    localparam logic [DIG_W-1:0] KEY_MAX_DIGIT = DIG_W'(9);
    localparam logic [DIG_W-1:0] KEY_CLEAR     = DIG_W'(10);
    localparam logic [DIG_W-1:0] KEY_ENTER     = DIG_W'(11);
    localparam logic [CNT_W-1:0] PIN_DIGITS    = CNT_W'(4);
    // Expiry fires on the idle cycle that would carry the timer to TIMEOUT_CYCLES-1.
    localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SEND,
        S_HOLD,
        S_LOCKED
    } state_t;

    state_t              state;
    logic [CODE_W-1:0]   buffer;
    logic [CNT_W-1:0]    count;
    logic [TMR_W-1:0]    timer;
    logic [CODE_W-1:0]   code_reg;
    logic                ack_reg;
    logic                error_reg;
    logic                timeout_reg;
    logic                busy_reg;

    assign bus.code        = code_reg;
    assign bus.code_ack    = ack_reg;
    assign bus.digit_count = count;
    assign bus.entry_error = error_reg;
    assign bus.timeout     = timeout_reg;
    assign bus.busy        = busy_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            buffer      <= '0;
            count       <= '0;
            timer       <= '0;
            code_reg    <= '0;
            ack_reg     <= 1'b0;
            error_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            ack_reg     <= 1'b0;
            error_reg   <= 1'b0;
            timeout_reg <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.vehicle_arrival) begin
                        state  <= S_COLLECT;
                        buffer <= '0;
                        count  <= '0;
                        timer  <= '0;
                    end
                end

                S_COLLECT: begin
                    // Vehicle leaving outranks any key pressed in the same cycle.
                    if (!bus.vehicle_arrival) begin
                        state  <= S_IDLE;
                        buffer <= '0;
                        count  <= '0;
                        timer  <= '0;
                    end else if (bus.key_valid) begin
                        timer <= '0;
                        if (bus.key_value <= KEY_MAX_DIGIT) begin
                            if (count < PIN_DIGITS) begin
                                buffer <= {buffer[CODE_W-DIG_W-1:0], bus.key_value};
                                count  <= count + CNT_W'(1);
                            end else begin
                                error_reg <= 1'b1;
                            end
                        end else if (bus.key_value == KEY_CLEAR) begin
                            buffer <= '0;
                            count  <= '0;
                        end else if (bus.key_value == KEY_ENTER) begin
                            if (count == PIN_DIGITS) begin
                                code_reg <= buffer;
                                state    <= S_SEND;
                                busy_reg <= 1'b1;
                            end else begin
                                error_reg <= 1'b1;
                                buffer    <= '0;
                                count     <= '0;
                            end
                        end
                    end else if (timer == TMR_LAST) begin
                        timeout_reg <= 1'b1;
                        buffer      <= '0;
                        count       <= '0;
                        timer       <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                S_SEND: begin
                    ack_reg <= 1'b1;
                    state   <= S_HOLD;
                end

                S_HOLD: begin
                    if (bus.blocked_gate) begin
                        state    <= S_LOCKED;
                        busy_reg <= 1'b0;
                    end else if (bus.open_gate) begin
                        state    <= S_IDLE;
                        buffer   <= '0;
                        count    <= '0;
                        busy_reg <= 1'b0;
                    end else if (bus.wrong_ping) begin
                        state    <= S_COLLECT;
                        buffer   <= '0;
                        count    <= '0;
                        timer    <= '0;
                        busy_reg <= 1'b0;
                    end
                end

                S_LOCKED: begin
                    state <= S_LOCKED;
                end

                default: begin
                    state    <= S_IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_keypad_encoder.sv
// Directed and randomized bench for parking_keypad_encoder, checked against
// a queue-based model of the PIN entry rules.
module tb_parking_keypad_encoder;

    localparam int unsigned TOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   va  = 1'b0;

    int checks   = 0;
    int failures = 0;

    parking_keypad_encoder_if bus ();

    parking_keypad_encoder #(
        .TIMEOUT_CYCLES(TOUT),
        .TMR_W         (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: phase flags, a digit queue and a count of consecutive idle cycles.
    bit          m_collect, m_send, m_hold, m_locked;
    int          q[$];
    int          m_idle;
    logic [15:0] m_code;
    bit          m_ack, m_err, m_to;

    function automatic void model_reset();
        m_collect = 0; m_send = 0; m_hold = 0; m_locked = 0;
        q.delete();
        m_idle = 0; m_code = 16'h0000;
        m_ack = 0; m_err = 0; m_to = 0;
    endfunction

    function automatic void model(input bit v, input bit kv, input int k,
                                  input bit og, input bit wp, input bit bg);
        m_ack = 0; m_err = 0; m_to = 0;
        if (m_locked) begin
        end else if (m_send) begin
            m_send = 0; m_hold = 1; m_ack = 1;
        end else if (m_hold) begin
            if (bg) begin m_hold = 0; m_locked = 1; end
            else if (og) begin m_hold = 0; q.delete(); end
            else if (wp) begin m_hold = 0; m_collect = 1; q.delete(); m_idle = 0; end
        end else if (!m_collect) begin
            if (v) begin m_collect = 1; q.delete(); m_idle = 0; end
        end else if (!v) begin
            m_collect = 0; q.delete(); m_idle = 0;
        end else if (kv) begin
            m_idle = 0;
            if (k <= 9) begin
                if (q.size() < 4) q.push_back(k);
                else m_err = 1;
            end else if (k == 10) begin
                q.delete();
            end else if (k == 11) begin
                if (q.size() == 4) begin
                    m_code = 16'((q[0] * 4096) + (q[1] * 256) + (q[2] * 16) + q[3]);
                    m_collect = 0; m_send = 1;
                end else begin
                    m_err = 1; q.delete();
                end
            end
        end else begin
            m_idle++;
            if (m_idle == int'(TOUT) - 1) begin
                m_to = 1; q.delete(); m_idle = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("code", bus.code, m_code);
        chk("code_ack", 16'(bus.code_ack), 16'(m_ack));
        chk("digit_count", 16'(bus.digit_count), 16'(q.size()));
        chk("entry_error", 16'(bus.entry_error), 16'(m_err));
        chk("timeout", 16'(bus.timeout), 16'(m_to));
        chk("busy", 16'(bus.busy), 16'(m_send || m_hold));
    endtask

    task automatic step(input bit kv, input logic [3:0] k, input bit og, input bit wp, input bit bg);
        bus.vehicle_arrival = va;
        bus.key_valid       = kv;
        bus.key_value       = k;
        bus.open_gate       = og;
        bus.wrong_ping      = wp;
        bus.blocked_gate    = bg;
        model(va, kv, int'(k), og, wp, bg);
        @(posedge clk);
        #1;
        check_all();
        bus.key_valid    = 1'b0;
        bus.open_gate    = 1'b0;
        bus.wrong_ping   = 1'b0;
        bus.blocked_gate = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        step(1'b1, k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        bus.vehicle_arrival = 1'b0;
        bus.key_valid       = 1'b0;
        bus.key_value       = 4'h0;
        bus.open_gate       = 1'b0;
        bus.wrong_ping      = 1'b0;
        bus.blocked_gate    = 1'b0;
        model_reset();
        apply_reset();

        // Basic PIN hand-off with ack latency and open_gate release
        va = 1'b1;
        idle_n(1);
        key(4'h2); key(4'h4); key(4'h6); key(4'h8);
        chk("t1_count4", 16'(bus.digit_count), 16'd4);
        key(4'hB);
        chk("t1_code", bus.code, 16'h2468);
        chk("t1_ack_not_yet", 16'(bus.code_ack), 16'd0);
        chk("t1_busy_send", 16'(bus.busy), 16'd1);
        idle_n(1);
        chk("t1_ack", 16'(bus.code_ack), 16'd1);
        idle_n(1);
        chk("t1_ack_single", 16'(bus.code_ack), 16'd0);
        chk("t1_busy_hold", 16'(bus.busy), 16'd1);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t1_idle_busy", 16'(bus.busy), 16'd0);
        chk("t1_idle_count", 16'(bus.digit_count), 16'd0);

        // Short ENTER and overflow digit
        idle_n(1);
        key(4'h1); key(4'h2); key(4'hB);
        chk("t2_short_err", 16'(bus.entry_error), 16'd1);
        chk("t2_short_count", 16'(bus.digit_count), 16'd0);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5);
        chk("t2_over_err", 16'(bus.entry_error), 16'd1);
        chk("t2_over_count", 16'(bus.digit_count), 16'd4);
        key(4'hB);
        chk("t2_code", bus.code, 16'h1234);
        idle_n(1);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("t2_retry_count", 16'(bus.digit_count), 16'd0);

        // Wrong PIN retry, then open_gate outranks wrong_ping
        key(4'h1); key(4'h3); key(4'h5); key(4'h7); key(4'hB);
        idle_n(1);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("t3_retry_count", 16'(bus.digit_count), 16'd0);
        key(4'h2); key(4'h4); key(4'h6); key(4'h8); key(4'hB);
        chk("t3_code", bus.code, 16'h2468);
        idle_n(1);
        chk("t3_ack2", 16'(bus.code_ack), 16'd1);
        step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        key(4'h5);
        chk("t3_idle_ignores_key", 16'(bus.digit_count), 16'd0);

        // Inactivity expiry and key-wins-over-expiry
        key(4'h9);
        idle_n(6);
        chk("t4_no_early_to", 16'(bus.timeout), 16'd0);
        idle_n(1);
        chk("t4_timeout", 16'(bus.timeout), 16'd1);
        chk("t4_to_count", 16'(bus.digit_count), 16'd0);
        key(4'h9);
        idle_n(6);
        key(4'h1);
        chk("t4_key_wins", 16'(bus.timeout), 16'd0);
        chk("t4_key_count", 16'(bus.digit_count), 16'd2);
        idle_n(7);
        chk("t4_timeout2", 16'(bus.timeout), 16'd1);
        key(4'h3);
        va = 1'b0;
        key(4'h4);
        chk("t4_leave_drops_key", 16'(bus.digit_count), 16'd0);

        // Locked gate ignores everything until reset
        va = 1'b1;
        idle_n(1);
        key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'hB);
        idle_n(1);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("t5_locked_busy", 16'(bus.busy), 16'd0);
        for (int i = 0; i < 50; i++) begin
            va = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("t5_locked_code", bus.code, 16'h9876);
        apply_reset();
        chk("t5_reset_code", bus.code, 16'h0000);

        // Asynchronous reset during the SEND cycle
        va = 1'b1;
        idle_n(1);
        key(4'h5); key(4'h6); key(4'h7); key(4'h8); key(4'hB);
        chk("t6_send_busy", 16'(bus.busy), 16'd1);
        #2;
        apply_reset();
        chk("t6_ack", 16'(bus.code_ack), 16'd0);
        chk("t6_code", bus.code, 16'h0000);
        idle_n(1);
        key(4'h3); key(4'hA); key(4'h4);
        chk("t6_count", 16'(bus.digit_count), 16'd1);
        key(4'h1); key(4'h2); key(4'h3); key(4'hB);
        chk("t6_buffer", bus.code, 16'h4123);
        idle_n(1);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [3:0] k;
            if ((m_locked && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0) begin
                apply_reset();
            end else begin
                va = ($urandom_range(0, 31) != 0);
                r = int'($urandom_range(0, 99));
                if (r < 70)      k = 4'($urandom_range(0, 9));
                else if (r < 75) k = 4'hA;
                else if (r < 95) k = 4'hB;
                else             k = 4'($urandom_range(12, 15));
                step($urandom_range(0, 2) == 0, k,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 29) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
